grey_dec: RTL and testbench
===========================

# grey_dec

Receive-side decoder for the 5-bit decade code driven by the `grey` counters. It samples a bank of `pDIGITS` cascaded digit codes that change asynchronously to `i_clk` and synchronizes them. It requires the sampled value to be stable, then publishes a BCD value with a one-cycle strobe. It flags illegal codes and, optionally, count skips. It sits in the `i_clk` domain, on the far side of any digit chain clocked by `i_cnt` and roll outputs.

## Interface
- `pDIGITS`, default 2: number of cascaded digits, 1..4; digit 0 is least significant.
- `pSTABLE`, default 2: consecutive identical synchronized samples needed before acceptance, 1..15.
- `i_clk`  in  1: system clock.
- `w_rst`  in  1: reset, synchronous, active-high; clock i_clk.
- `i_grey`  in  5*pDIGITS: digit codes; digit k in bits [5k+4:5k]; asynchronous to `i_clk`.
- `o_bcd`  out  4*pDIGITS: last accepted value, BCD, digit k in bits [4k+3:4k].
- `o_valid`  out  1: one-cycle strobe; `o_bcd` was updated this cycle.
- `o_err`  out  1: one-cycle strobe; a stable sample contained an illegal code.
- `o_skip`  out  1: one-cycle strobe, coincident with `o_valid`; the new value is not the previous value +1 (mod 10^pDIGITS).

## Operation
- Legal codes for 0..9: 11000, 11001, 10001, 10011, 00011, 00111, 00110, 01110, 01100, 11100. All other 22 codes are illegal.
- Synchronizer: two flops on all `i_grey` bits, s1 then s2. A single-bit change per step means a mid-transition sample resolves to the old or the new code.
- Stability tracker, every cycle:
  - r_last <= s2.
  - If s2 != r_last, cnt <= 0.
  - Otherwise cnt <= min(cnt+1, pSTABLE).
- Accept event: s2 == r_last and cnt == pSTABLE-1, so cnt reaches pSTABLE. It fires exactly once per stable period.
- On an accept event:
  - Any digit illegal: `o_err`=1. `o_bcd` and r_pub are unchanged.
  - Else, if r_first=1 or s2 != r_pub: r_pub <= s2, `o_bcd` <= decoded value, `o_valid`=1, r_first <= 0.
  - Else (same as already published): no strobe.
- Skip check on publish, only when r_first=0: `o_skip`=1 iff new `o_bcd` != old `o_bcd` + 1 in BCD, mod 10^pDIGITS.
  - 9..9 -> 0..0 is not a skip.
  - The first publish after reset never skips.
- Cascade incoherence: during 09->10, digit 1 and digit 0 may be sampled at different times, giving 19 or 00. The `pSTABLE` filter suppresses these when their duration is under pSTABLE cycles. If they last longer, they are published and flagged by `o_skip`.
- Reset values:
  - `o_bcd`=0, `o_valid`=0, `o_err`=0, `o_skip`=0.
  - s1, s2, r_last and r_pub = 11000 in every digit.
  - cnt=0, r_first=1.

## Timing
- An `i_grey` change meeting setup before edge 0 appears in s1 at edge 1 and s2 at edge 2. cnt clears at edge 3.
- The accept event and strobes occur at edge 3+pSTABLE (edge 5 for default). `o_bcd` changes at that same edge.
- An input held fewer than pSTABLE+1 cycles in s2 is never accepted.
- An input change during the count restarts the count; nothing is published for the interrupted value.
- `w_rst` asserted at any edge forces the reset state at that edge, aborting any in-progress count. After deassertion, a stable input 0..0 is published with `o_valid` (r_first) at edge 3+pSTABLE relative to the first non-reset edge.
- Strobes are registered, never asserted two consecutive cycles, and `o_err` and `o_valid` are mutually exclusive.

## Configuration
- `GREY_DEC_SKIP_EN`:
  - Defined: skip checker (BCD incrementer + comparator) is built; `o_skip` behaves as above.
  - Undefined: checker is omitted; `o_skip` is tied 0; all other behaviour is identical.

## Structure
- Shared package `grey_pkg` holds:
  - the ten code constants and `GREY_W`=5;
  - decode function code->{legal, bcd[3:0]};
  - encode function bcd->code.
- The `grey` counter is updated to use the same package.
- Sub-module `grey_dec_digit`, instantiated per digit: two-flop synchronizer plus registered decode, outputting s2, legal and bcd.
- The top level holds the stability counter, publish logic and skip checker.

## Test plan
- Reset, `i_grey`={11000,11000} held: one `o_valid` at edge 5 after reset release, `o_bcd`=0x00, `o_skip`=0.
- Step 00->01: `o_valid` 5 edges after the change, `o_bcd`=0x01, `o_skip`=0. Stepping 01..99 by +1 at 10-cycle spacing gives 99 strobes, no skips, no `o_err`.
- 09->10 with digit 0 updated 1 cycle before digit 1 (transient 00): a single publish of 0x10, `o_skip`=0. Repeat with a 6-cycle gap: publishes 0x00 with `o_skip`=1, then 0x10 with `o_skip`=1 (macro defined; 0 when undefined).
- Digit 0 set to 10101 and held: `o_err` pulse at edge 5, `o_bcd` unchanged, no `o_valid`, no repeat pulse while held.
- Digit 0 glitches 0->1->0 for 2 cycles at s2: no strobes.
- 99->00 wrap: `o_valid`, `o_skip`=0. 03->05 jump: `o_skip`=1. `w_rst` pulse mid-count: no strobe for the interrupted value; the republish follows the reset rule.

Source files
------------

// File: rtl/grey_pkg.sv
// grey_pkg: the 5-bit decade code shared by the grey counters and decoder.
// It holds the ten code constants, code->{legal,bcd} decode and bcd->code encode.
package grey_pkg;
    localparam int GREY_W = 5;
    localparam logic [GREY_W-1:0] CODE_0 = 5'b11000;
    localparam logic [GREY_W-1:0] CODE_1 = 5'b11001;
    localparam logic [GREY_W-1:0] CODE_2 = 5'b10001;
    localparam logic [GREY_W-1:0] CODE_3 = 5'b10011;
    localparam logic [GREY_W-1:0] CODE_4 = 5'b00011;
    localparam logic [GREY_W-1:0] CODE_5 = 5'b00111;
    localparam logic [GREY_W-1:0] CODE_6 = 5'b00110;
    localparam logic [GREY_W-1:0] CODE_7 = 5'b01110;
    localparam logic [GREY_W-1:0] CODE_8 = 5'b01100;
    localparam logic [GREY_W-1:0] CODE_9 = 5'b11100;
    localparam logic [GREY_W-1:0] CODES [10] = '{CODE_0, CODE_1, CODE_2, CODE_3, CODE_4,
                                                  CODE_5, CODE_6, CODE_7, CODE_8, CODE_9};

    typedef struct packed {
        logic       legal;
        logic [3:0] bcd;
    } grey_dec_t;

    function automatic grey_dec_t grey_decode(input logic [GREY_W-1:0] code);
        grey_decode = '{legal: 1'b0, bcd: 4'd0};
        for (int i = 0; i < 10; i++)
            if (code == CODES[i]) grey_decode = '{legal: 1'b1, bcd: 4'(i)};
    endfunction

    function automatic logic [GREY_W-1:0] grey_encode(input logic [3:0] bcd);
        case (bcd)
            4'd1:    grey_encode = CODE_1;
            4'd2:    grey_encode = CODE_2;
            4'd3:    grey_encode = CODE_3;
            4'd4:    grey_encode = CODE_4;
            4'd5:    grey_encode = CODE_5;
            4'd6:    grey_encode = CODE_6;
            4'd7:    grey_encode = CODE_7;
            4'd8:    grey_encode = CODE_8;
            4'd9:    grey_encode = CODE_9;
            default: grey_encode = CODE_0;
        endcase
    endfunction
endpackage

// File: rtl/grey_dec_digit.sv
// grey_dec_digit: two-flop synchronizer for one digit code plus a registered decode of s2.
module grey_dec_digit
    import grey_pkg::*;
(
    input  logic              i_clk,
    input  logic              w_rst,
    input  logic [GREY_W-1:0] i_code,
    output logic [GREY_W-1:0] o_s2,
    output logic              o_legal,
    output logic [3:0]        o_bcd
);
    logic [GREY_W-1:0] r_s1, r_s2;
    grey_dec_t w_dec;

    assign w_dec = grey_decode(r_s2);
    assign o_s2  = r_s2;

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_s1    <= CODE_0;
            r_s2    <= CODE_0;
            o_legal <= 1'b1;
            o_bcd   <= 4'd0;
        end else begin
            r_s1    <= i_code;
            r_s2    <= r_s1;
            o_legal <= w_dec.legal;
            o_bcd   <= w_dec.bcd;
        end
    end
endmodule

// File: rtl/grey_dec.sv
// grey_dec: synchronizes a bank of decade-code digits, filters for stability, publishes BCD with strobes.
// Define GREY_DEC_SKIP_EN to build the count-skip checker; otherwise o_skip is tied low.
module grey_dec
    import grey_pkg::*;
#(
    parameter int pDIGITS = 2,
    parameter int pSTABLE = 2
) (
    input  logic                      i_clk,
    input  logic                      w_rst,
    input  logic [GREY_W*pDIGITS-1:0] i_grey,
    output logic [4*pDIGITS-1:0]      o_bcd,
    output logic                      o_valid,
    output logic                      o_err,
    output logic                      o_skip
);
    localparam int CW = 4;

    logic [GREY_W*pDIGITS-1:0] w_s2, r_last, r_pub;
    logic [pDIGITS-1:0]        w_legal;
    logic [4*pDIGITS-1:0]      w_dbcd;
    logic [CW-1:0]             r_cnt;
    logic [1:0]                r_warm;
    logic                      r_lv, r_first, w_same, w_accept, w_ok, w_pub;

    for (genvar d = 0; d < pDIGITS; d++) begin : g_dig
        grey_dec_digit u_digit (
            .i_clk   (i_clk),
            .w_rst   (w_rst),
            .i_code  (i_grey[GREY_W*d +: GREY_W]),
            .o_s2    (w_s2[GREY_W*d +: GREY_W]),
            .o_legal (w_legal[d]),
            .o_bcd   (w_dbcd[4*d +: 4])
        );
    end

    // Reset contents of s1/s2 are not real samples, so r_last only counts once true data reached it.
    assign w_same   = r_lv && (w_s2 == r_last);
    assign w_accept = w_same && (r_cnt == CW'(pSTABLE - 1));
    assign w_ok     = &w_legal;
    assign w_pub    = w_accept && w_ok && (r_first || (w_s2 != r_pub));

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_warm  <= 2'b00;
            r_lv    <= 1'b0;
            r_last  <= {pDIGITS{CODE_0}};
            r_pub   <= {pDIGITS{CODE_0}};
            r_cnt   <= '0;
            r_first <= 1'b1;
            o_bcd   <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_warm  <= {r_warm[0], 1'b1};
            r_lv    <= r_warm[1];
            r_last  <= w_s2;
            r_cnt   <= !w_same ? '0 : (r_cnt == CW'(pSTABLE) ? r_cnt : r_cnt + 1'b1);
            o_valid <= w_pub;
            o_err   <= w_accept && !w_ok;
            if (w_pub) begin
                r_pub   <= w_s2;
                o_bcd   <= w_dbcd;
                r_first <= 1'b0;
            end
        end
    end

`ifdef GREY_DEC_SKIP_EN
    logic [4*pDIGITS-1:0] w_inc;
    logic                 w_carry;

    always_comb begin
        w_inc   = o_bcd;
        w_carry = 1'b1;
        for (int k = 0; k < pDIGITS; k++) begin
            w_inc[4*k +: 4] = !w_carry ? o_bcd[4*k +: 4] :
                              (o_bcd[4*k +: 4] == 4'd9 ? 4'd0 : o_bcd[4*k +: 4] + 4'd1);
            w_carry = w_carry && (o_bcd[4*k +: 4] == 4'd9);
        end
    end

    always_ff @(posedge i_clk)
        o_skip <= w_rst ? 1'b0 : (w_pub && !r_first && (w_dbcd != w_inc));
`else
    assign o_skip = 1'b0;
`endif
endmodule

// File: tb/tb_grey_dec.sv
// tb_grey_dec: vector table, hand-written corner sequences and random segments against a history-based model.
module tb_grey_dec;
    localparam int D = 2;
    localparam int S = 2;
`ifdef GREY_DEC_SKIP_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam logic [4:0] CODES [10] = '{5'b11000, 5'b11001, 5'b10001, 5'b10011, 5'b00011,
                                          5'b00111, 5'b00110, 5'b01110, 5'b01100, 5'b11100};

    typedef struct {
        int d1;
        int d0;
        int hold;
        int nv;
        int ns;
        int ne;
        int bcd;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       w_rst = 1'b1;
    logic [9:0] i_grey = 10'b11000_11000;
    logic [7:0] o_bcd;
    logic       o_valid, o_err, o_skip;

    int tests = 0;
    int fails = 0;
    int cnt_v, cnt_s, cnt_e;

    logic [9:0] hist [$];
    logic       m_first = 1'b1;
    logic [9:0] m_pub;
    int         m_int = 0;
    logic       e_valid, e_err, e_skip;

    grey_dec #(.pDIGITS(D), .pSTABLE(S)) dut (
        .i_clk   (i_clk),
        .w_rst   (w_rst),
        .i_grey  (i_grey),
        .o_bcd   (o_bcd),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_skip  (o_skip)
    );

    always #5 i_clk = ~i_clk;

    function automatic int dig(input logic [4:0] c);
        for (int i = 0; i < 10; i++)
            if (c == CODES[i]) return i;
        return -1;
    endfunction

    function automatic logic [9:0] enc(input int v);
        return {CODES[(v / 10) % 10], CODES[v % 10]};
    endfunction

    // A value is accepted on the edge where its sampled run first reaches S+1 samples (two edges of sync delay).
    task automatic model(input logic [9:0] g, input logic rst);
        int n, d1, d0, v;
        logic acc;
        logic [9:0] cur;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_skip  = 1'b0;
        if (rst) begin
            hist.delete();
            m_first = 1'b1;
            m_pub   = enc(0);
            m_int   = 0;
            return;
        end
        hist.push_back(g);
        n = hist.size() - 1;
        acc = (n >= 2 + S);
        if (!acc) return;
        cur = hist[n-2];
        for (int i = n - 2 - S; i < n - 2; i++)
            if (hist[i] != cur) acc = 1'b0;
        if (acc && n >= 3 + S && hist[n-3-S] == cur) acc = 1'b0;
        if (!acc) return;
        d1 = dig(cur[9:5]);
        d0 = dig(cur[4:0]);
        if (d1 < 0 || d0 < 0) begin
            e_err = 1'b1;
        end else if (m_first || cur != m_pub) begin
            v       = d1 * 10 + d0;
            e_valid = 1'b1;
            e_skip  = (SK != 0) && !m_first && (v != (m_int + 1) % 100);
            m_pub   = cur;
            m_int   = v;
            m_first = 1'b0;
        end
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] g, input logic rst);
        i_grey = g;
        w_rst  = rst;
        @(posedge i_clk);
        model(g, rst);
        #1;
        cmp("valid", int'(o_valid), int'(e_valid));
        cmp("err", int'(o_err), int'(e_err));
        cmp("skip", int'(o_skip), int'(e_skip));
        cmp("bcd", int'(o_bcd), (m_int / 10) * 16 + m_int % 10);
        cnt_v += int'(o_valid);
        cnt_s += int'(o_skip);
        cnt_e += int'(o_err);
    endtask

    task automatic hold(input logic [9:0] g, input int n);
        for (int i = 0; i < n; i++) step(g, 1'b0);
    endtask

    task automatic clr();
        cnt_v = 0;
        cnt_s = 0;
        cnt_e = 0;
    endtask

    initial begin
        vec_t vecs [9];
        logic [9:0] g;
        int first_at, v;
        vecs = '{
            '{0, 0, 8, 1, 0, 0, 'h00},
            '{0, 1, 8, 1, 0, 0, 'h01},
            '{0, 3, 8, 1, SK, 0, 'h03},
            '{0, 5, 8, 1, SK, 0, 'h05},
            '{0, -1, 8, 0, 0, 1, 'h05},
            '{9, 9, 8, 1, SK, 0, 'h99},
            '{0, 0, 8, 1, 0, 0, 'h00},
            '{0, 1, 2, 0, 0, 0, 'h00},
            '{0, 0, 8, 0, 0, 0, 'h00}
        };
        clr();
        for (int i = 0; i < 3; i++) step(enc(0), 1'b1);
        foreach (vecs[i]) begin
            clr();
            g = {CODES[vecs[i].d1], vecs[i].d0 < 0 ? 5'b10101 : CODES[vecs[i].d0]};
            hold(g, vecs[i].hold);
            cmp($sformatf("vec%0d_nvalid", i), cnt_v, vecs[i].nv);
            cmp($sformatf("vec%0d_nskip", i), cnt_s, vecs[i].ns);
            cmp($sformatf("vec%0d_nerr", i), cnt_e, vecs[i].ne);
            cmp($sformatf("vec%0d_bcd", i), int'(o_bcd), vecs[i].bcd);
        end

        clr();
        for (int n = 1; n < 100; n++) hold(enc(n), 10);
        cmp("count_nvalid", cnt_v, 99);
        cmp("count_nskip", cnt_s, 0);
        cmp("count_nerr", cnt_e, 0);

        hold(enc(9), 10);
        clr();
        hold(enc(0), 1);
        hold(enc(10), 10);
        cmp("casc1_nvalid", cnt_v, 1);
        cmp("casc1_nskip", cnt_s, 0);
        cmp("casc1_bcd", int'(o_bcd), 'h10);

        hold(enc(9), 10);
        clr();
        hold(enc(0), 6);
        hold(enc(10), 10);
        cmp("casc6_nvalid", cnt_v, 2);
        cmp("casc6_nskip", cnt_s, 2 * SK);

        hold(enc(25), 3);
        clr();
        step(enc(25), 1'b1);
        first_at = 0;
        for (int k = 1; k <= 8; k++) begin
            step(enc(25), 1'b0);
            if (o_valid && first_at == 0) first_at = k;
        end
        cmp("rst_pub_edge", first_at, 5);
        cmp("rst_nvalid", cnt_v, 1);
        cmp("rst_nskip", cnt_s, 0);

        v = 25;
        for (int s = 0; s < 500; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int r = 0; r < int'($urandom_range(1, 2)); r++) step(enc(v), 1'b1);
            end
            case ($urandom_range(0, 5))
                0:       g = 10'($urandom);
                1, 2:    begin v = (v + 1) % 100; g = enc(v); end
                default: begin v = $urandom_range(0, 99); g = enc(v); end
            endcase
            hold(g, $urandom_range(1, 7));
        end
        hold(enc(v), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
